// File: rtl/decompressor_top.sv
// Literal/copy item decompressor: each item expands into 1..16 bytes through a history ring buffer.
// Optional macro DECOMP_OFFSET_CHECK_EN zeroes copy bytes whose offset points outside written history.
module decompressor_top #(
    parameter int HISTORY_SIZE = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        control_word_in,
    input  logic        data_in_valid,
    output logic [7:0]  decompressed_byte,
    output logic        out_valid,
    output logic        decompressor_busy
);
    localparam int AW = $clog2(HISTORY_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [15:0]     item_r;
    logic            is_copy_r;
    logic [4:0]      idx_r;
    logic [AW-1:0]   wp_r;
    logic [7:0]      hist_r [HISTORY_SIZE];

    logic            accept_s;
    logic            emit_s;
    logic [4:0]      len_s;
    logic [11:0]     offset_s;
    logic [AW-1:0]   rd_addr_s;
    logic [7:0]      hist_byte_s;
    logic [7:0]      byte_s;

    // Item decode, history read address and per-edge emit decision
    always_comb begin
        offset_s  = {item_r[15:12], item_r[7:0]};
        rd_addr_s = AW'(32'(wp_r) - 32'(offset_s));
        if (is_copy_r) begin
            len_s = {1'b0, item_r[11:8]} + 5'd1;
        end else begin
            len_s = 5'd1;
        end
        accept_s = (state_r == IDLE) && data_in_valid;
        emit_s   = (state_r == EMIT) && (idx_r != len_s);
    end

    assign hist_byte_s = hist_r[rd_addr_s];

`ifdef DECOMP_OFFSET_CHECK_EN
    localparam logic [AW:0] HIST_FULL = (AW+1)'(HISTORY_SIZE);

    logic [AW:0] count_r;
    logic        offset_bad_s;

    // Saturating count of bytes produced since reset
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {(AW+1){1'b0}};
        end else if (emit_s && (count_r != HIST_FULL)) begin
            count_r <= count_r + (AW+1)'(1);
        end
    end

    // Byte source with out-of-history copies forced to zero
    always_comb begin
        offset_bad_s = (offset_s == 12'd0) ||
                       (32'(offset_s) > 32'(count_r)) ||
                       (32'(offset_s) >= 32'(HISTORY_SIZE));
        if (!is_copy_r) begin
            byte_s = item_r[7:0];
        end else if (offset_bad_s) begin
            byte_s = 8'h00;
        end else begin
            byte_s = hist_byte_s;
        end
    end
`else
    // Byte source: latched literal or raw wrapped history read
    always_comb begin
        if (!is_copy_r) begin
            byte_s = item_r[7:0];
        end else begin
            byte_s = hist_byte_s;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                if (emit_s) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Item latch, byte counter, write pointer and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            item_r            <= 16'h0000;
            is_copy_r         <= 1'b0;
            idx_r             <= 5'd0;
            wp_r              <= {AW{1'b0}};
            out_valid         <= 1'b0;
            decompressed_byte <= 8'h00;
        end else if (accept_s) begin
            item_r    <= data_in;
            is_copy_r <= control_word_in;
            idx_r     <= 5'd0;
            out_valid <= 1'b0;
        end else if (emit_s) begin
            idx_r             <= idx_r + 5'd1;
            wp_r              <= wp_r + AW'(1);
            out_valid         <= 1'b1;
            decompressed_byte <= byte_s;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // History write; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (!reset && emit_s) begin
            hist_r[wp_r] <= byte_s;
        end
    end

    assign decompressor_busy = (state_r == EMIT);

endmodule

// File: tb/tb_decompressor_top.sv
// Self-checking bench for decompressor_top: directed vector table, hand-written corner sequences
// and random items checked every cycle against a byte-stream reference model.
module tb_decompressor_top;
    localparam int HS = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        data_in_valid;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        decompressor_busy;

    decompressor_top #(.HISTORY_SIZE(HS)) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .control_word_in(control_word_in),
        .data_in_valid(data_in_valid),
        .decompressed_byte(decompressed_byte),
        .out_valid(out_valid),
        .decompressor_busy(decompressor_busy)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] got_q [$];
    int         busy_cnt = 0;

    // Reference model: item-level view of the output byte stream
    logic [7:0]  m_hist [HS];
    int          m_wp = 0;
    int          m_cnt = 0;
    int          m_rem = 0;
    bit          m_busy = 1'b0;
    bit          m_ov = 1'b0;
    bit          m_cw = 1'b0;
    logic [15:0] m_data = 16'h0000;
    logic [7:0]  m_byte = 8'h00;

    typedef struct {
        logic        cw;
        logic [15:0] d;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  bl;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte();
        int off;
        int idx;
        if (!m_cw) return m_data[7:0];
        off = int'({m_data[15:12], m_data[7:0]});
`ifdef DECOMP_OFFSET_CHECK_EN
        if (off == 0 || off > m_cnt || off >= HS) return 8'h00;
`endif
        idx = ((m_wp - off) % HS + HS) % HS;
        return m_hist[idx];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_busy = 1'b0; m_ov = 1'b0; m_byte = 8'h00;
            m_wp = 0; m_cnt = 0; m_rem = 0;
        end else if (!m_busy) begin
            m_ov = 1'b0;
            if (data_in_valid) begin
                m_busy = 1'b1;
                m_cw   = control_word_in;
                m_data = data_in;
                m_rem  = control_word_in ? int'(data_in[11:8]) + 1 : 1;
            end
        end else if (m_rem > 0) begin
            m_byte = ref_byte();
            m_hist[m_wp] = m_byte;
            m_wp = (m_wp + 1) % HS;
            if (m_cnt < HS) m_cnt++;
            m_rem--;
            m_ov = 1'b1;
        end else begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
        end
    endtask

    // Advance the model on each edge and compare all outputs just after it
    always @(posedge clock) begin
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("busy", 32'(decompressor_busy), 32'(m_busy));
        chk("byte", 32'(decompressed_byte), 32'(m_byte));
        if (out_valid) got_q.push_back(decompressed_byte);
        if (decompressor_busy) busy_cnt++;
    end

    task automatic send_item(input logic c, input logic [15:0] d);
        int guard = 0;
        @(negedge clock);
        while (decompressor_busy && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        got_q.delete();
        busy_cnt = 0;
        data_in = d;
        control_word_in = c;
        data_in_valid = 1'b1;
        @(negedge clock);
        data_in_valid = 1'b0;
        guard = 0;
        while (decompressor_busy && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 40) chk("item_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  exp_b;
        logic [11:0] off;
        logic [3:0]  len;
        int          guard;
        int          n_exp;

        for (int i = 0; i < HS; i++) m_hist[i] = 8'h00;
        vecs[0] = '{1'b0, 16'h0061, 1,  8'h61, 8'h61};
        vecs[1] = '{1'b0, 16'h0061, 1,  8'h61, 8'h61};
        vecs[2] = '{1'b0, 16'h0062, 1,  8'h62, 8'h62};
        vecs[3] = '{1'b0, 16'h0063, 1,  8'h63, 8'h63};
        vecs[4] = '{1'b1, 16'h0203, 3,  8'h61, 8'h63};
        vecs[5] = '{1'b0, 16'h0078, 1,  8'h78, 8'h78};
        vecs[6] = '{1'b1, 16'h0F01, 16, 8'h78, 8'h78};

        reset = 1'b1;
        data_in = 16'h0000;
        control_word_in = 1'b0;
        data_in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(decompressor_busy), 32'd0);
        chk("reset_byte", 32'(decompressed_byte), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            send_item(vecs[v].cw, vecs[v].d);
            chk("vec_nbytes", 32'(got_q.size()), 32'(vecs[v].n));
            chk("vec_busy_cycles", 32'(busy_cnt), 32'(vecs[v].n + 1));
            if (got_q.size() > 0) begin
                chk("vec_first", 32'(got_q[0]), 32'(vecs[v].b0));
                chk("vec_last", 32'(got_q[got_q.size()-1]), 32'(vecs[v].bl));
            end
        end

        // Wrap-around: 20 literals through a 16-byte history, then copy offset 15 len 3
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 20; i++) send_item(1'b0, 16'h0041 + 16'(i));
        send_item(1'b1, 16'h020F);
        chk("wrap_nbytes", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("wrap_b0", 32'(got_q[0]), 32'h46);
            chk("wrap_b1", 32'(got_q[1]), 32'h47);
            chk("wrap_b2", 32'(got_q[2]), 32'h48);
        end

        // Inputs changing while busy are ignored; held literal is taken right after busy falls
        @(negedge clock);
        got_q.delete();
        data_in = 16'h0301; control_word_in = 1'b1; data_in_valid = 1'b1;
        @(negedge clock);
        for (int j = 0; j < 5; j++) begin
            data_in = 16'($urandom);
            control_word_in = 1'($urandom);
            @(negedge clock);
        end
        data_in = 16'h0055; control_word_in = 1'b0;
        @(negedge clock);
        data_in_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("ignore_nbytes", 32'(got_q.size()), 32'd5);
        if (got_q.size() == 5) begin
            chk("ignore_copy0", 32'(got_q[0]), 32'h48);
            chk("ignore_copy3", 32'(got_q[3]), 32'h48);
            chk("ignore_next", 32'(got_q[4]), 32'h55);
        end

        // Reset during the fifth byte of a long copy
        got_q.delete();
        data_in = 16'h0901; control_word_in = 1'b1; data_in_valid = 1'b1;
        @(negedge clock);
        data_in_valid = 1'b0;
        guard = 0;
        while (got_q.size() < 5 && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 40) chk("midreset_timeout", 32'd1, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_busy", 32'(decompressor_busy), 32'd0);
        reset = 1'b0;
`ifdef DECOMP_OFFSET_CHECK_EN
        exp_b = 8'h00;
`else
        exp_b = m_hist[HS-1];
`endif
        send_item(1'b1, 16'h0001);
        chk("postreset_nbytes", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("postreset_byte", 32'(got_q[0]), 32'(exp_b));

        // Random items with random gaps
        for (int r = 0; r < 150; r++) begin
            repeat ($urandom_range(0, 3)) begin
                data_in = 16'($urandom);
                @(negedge clock);
            end
            if ($urandom_range(0, 1) == 1) begin
                off = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 17));
                len = 4'($urandom);
                n_exp = int'(len) + 1;
                send_item(1'b1, {off[11:8], len, off[7:0]});
            end else begin
                n_exp = 1;
                send_item(1'b0, 16'($urandom));
            end
            chk("rand_nbytes", 32'(got_q.size()), 32'(n_exp));
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
